io_pwm_bank: RTL and testbench
==============================

# io_pwm_bank

Memory-mapped PWM peripheral that sits directly downstream of the processor's memory stage. It decodes IO accesses from the `IOinsn`/`memAddr`/`dataIn` bus and drives six PWM channels on the `JA` header. It returns readback data on `dataOut`, which the memory stage muxes into `CPUmemDataIn` in the same cycle. Writes are registered; reads are combinational, so a load's readback lands in the M/W latch without extra latency.

## Interface
- `CNT_W`, default 22: width of the period counter and of the duty and period registers (covers 700000-cycle frames).
- `NCH`, default 6: PWM channel count; must equal the `JA` width.

- `clock`  in  1: master clock.
- `reset`  in  1: synchronous, active-high.
- `IOinsn`  in  1: IO access strobe for this cycle (load or store with `memAddr[13:12]` != 00).
- `memAddr`  in  32: byte/word address from the ALU output.
- `dataIn`  in  32: store data.
- `dataOut`  out  32: readback data, combinational.
- `JA`  out  NCH: registered PWM outputs.

## Operation
- Decode by `memAddr[13:12]`:
  - 01 = write, active only when `IOinsn` is high.
  - 10 = read.
  - 11 = invalid: no write, `dataOut` = 0.
  - 00 = not this block.
- Register offsets (`memAddr[3:0]`):
  - 0–5: duty ch0–5, CNT_W bits.
  - 6: period, CNT_W bits.
  - 7: enable mask, NCH bits.
  - 8: counter, read-only.
  - 9: status, read-only.
  - All other offsets: writes ignored, reads return 0.
- Write data is `dataIn[CNT_W-1:0]`; upper bits are dropped. Reads are zero-extended to 32 bits.
- Counter `cnt`:
  - If active period P = 0: `cnt` is held at 0 and all channels are low.
  - Otherwise `cnt` counts 0..P-1 and wraps to 0.
  - If `cnt` ≥ P-1 (e.g. after P shrinks), the next value is 0.
- Channel output: JA[i] is the registered value of (`en[i]` && `cnt` < `duty_act[i]`).
  - Duty 0 gives a constant low output.
  - Duty ≥ P gives a constant high output.
- Wrap event: `cnt` = P-1 with P ≠ 0.
- Status bit 0 is the sticky wrap flag:
  - Set on every wrap event.
  - Cleared on the edge that ends a read of offset 9 (`IOinsn` high, `memAddr[13:12]` = 10).
  - A wrap event and a clearing read in the same cycle leave the flag set.
  - Status bits 31:1 read as 0.
- Enable-mask writes always take effect directly on the next edge.

## Timing
- Reset: `cnt`, all duty/period registers (active and pending), `en`, status and `JA` all become 0 on the edge where `reset` is high.
- Reset mid-frame aborts the frame immediately.
- Write latency: a register updates on the edge at the end of the `IOinsn` cycle. Without shadowing, the new value is used in the compare on the next cycle, and `JA` reflects it one cycle after that.
- `JA` lags `cnt` by exactly one cycle.
- `dataOut` is a pure function of `memAddr` and the current registers. It has no wait states and no handshake.
- Offsets 0–6 read back the **active** values.

## Configuration
- `IO_PWM_SHADOW_EN` defined:
  - Duty and period writes go to pending registers.
  - Pending registers copy to active on the edge of a wrap event, or on the next edge if the active P = 0.
  - A write in the same cycle as a wrap is forwarded into that transfer.
  - Frames never glitch.
- `IO_PWM_SHADOW_EN` undefined: duty and period writes update the active registers directly; there are no pending registers.

## Test plan
- Reset: hold `reset` for 2 cycles after random prior writes → `JA` = 0, reads of offsets 0–9 = 0.
- Basic PWM (shadow off): write period 10, duty0 3, enable 0x01 → `JA[0]` high exactly 3 of every 10 cycles, `JA[5:1]` = 0, counter readback at offset 8 cycles 0..9.
- Duty extremes: duty1 0 and duty2 15 with period 10, enable 0x06 → `JA[1]` constantly 0, `JA[2]` constantly 1.
- Shadow (macro on): period 10, duty0 3, then write duty0 8 at `cnt` = 4 → current frame stays 3 high; the next frame is 8 high. Offset 0 reads 3 until the wrap, then 8.
- Status: run until the wrap flag sets → offset 9 reads 1; after the read cycle it reads 0. A read coinciding with a wrap leaves the flag at 1.
- Period 0 and invalid space: write period 0 → `cnt` stays 0 and `JA` = 0. Write to `memAddr[13:12]` = 11 → no register changes, `dataOut` = 0.

Source files
------------

// File: rtl/io_pwm_bank.sv
// Memory-mapped six-channel PWM bank decoded from the memory-stage IO bus.
// Define IO_PWM_SHADOW_EN to double-buffer duty/period writes until the frame wraps.
module io_pwm_bank #(
   parameter int CNT_W = 22,
   parameter int NCH   = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             IOinsn,
   input  logic [31:0]      memAddr,
   input  logic [31:0]      dataIn,
   output logic [31:0]      dataOut,
   output logic [NCH-1:0]   JA
);

   typedef enum logic [1:0] {
      SEL_NONE    = 2'b00,
      SEL_WRITE   = 2'b01,
      SEL_READ    = 2'b10,
      SEL_INVALID = 2'b11
   } sel_e;

   localparam logic [3:0] OFF_PERIOD = 4'd6;
   localparam logic [3:0] OFF_EN     = 4'd7;
   localparam logic [3:0] OFF_CNT    = 4'd8;
   localparam logic [3:0] OFF_STATUS = 4'd9;

   sel_e             w_sel;
   logic [3:0]       w_off;
   logic             w_wr;
   logic             w_clr;
   logic [CNT_W-1:0] w_wdata;
   logic             w_run;
   logic [CNT_W-1:0] w_last;
   logic             w_wrap;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [NCH-1:0]   w_ja_nxt;
   logic             w_unused;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_duty [NCH];
   logic [NCH-1:0]   r_en;
   logic             r_wrap_flag;
   logic [NCH-1:0]   r_ja;

   assign w_sel    = sel_e'(memAddr[13:12]);
   assign w_off    = memAddr[3:0];
   assign w_wr     = IOinsn && (w_sel == SEL_WRITE);
   assign w_clr    = IOinsn && (w_sel == SEL_READ) && (w_off == OFF_STATUS);
   assign w_wdata  = dataIn[CNT_W-1:0];
   assign w_unused = ^{memAddr[31:14], memAddr[11:4], dataIn[31:CNT_W]};

   // w_last underflows when the period is 0; w_run masks every use of it.
   assign w_run     = (r_period != '0);
   assign w_last    = r_period - 1'b1;
   assign w_wrap    = w_run && (r_cnt == w_last);
   assign w_cnt_nxt = (!w_run || (r_cnt >= w_last)) ? '0 : r_cnt + 1'b1;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_ja_nxt[i] = w_run && r_en[i] && (r_cnt < r_duty[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= '0;
         r_en        <= '0;
         r_wrap_flag <= 1'b0;
         r_ja        <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_ja  <= w_ja_nxt;
         if (w_wr && (w_off == OFF_EN)) begin
            r_en <= dataIn[NCH-1:0];
         end
         // A wrap outranks a clearing read landing in the same cycle.
         if (w_wrap) begin
            r_wrap_flag <= 1'b1;
         end else if (w_clr) begin
            r_wrap_flag <= 1'b0;
         end
      end
   end

`ifdef IO_PWM_SHADOW_EN
   logic [CNT_W-1:0] r_period_pend;
   logic [CNT_W-1:0] r_duty_pend [NCH];
   logic [CNT_W-1:0] w_period_fwd;
   logic [CNT_W-1:0] w_duty_fwd [NCH];
   logic             w_load;

   // Pending values with this cycle's write folded in, so a write that
   // coincides with the wrap still lands in the next frame.
   always_comb begin
      w_period_fwd = r_period_pend;
      w_duty_fwd   = r_duty_pend;
      if (w_wr && (w_off == OFF_PERIOD)) begin
         w_period_fwd = w_wdata;
      end
      for (int i = 0; i < NCH; i++) begin
         if (w_wr && (w_off == 4'(i))) begin
            w_duty_fwd[i] = w_wdata;
         end
      end
   end

   assign w_load = w_wrap || !w_run;

   // NOTE: the duty bank is a handful of flops rather than a RAM, so it is
   // reset explicitly like any other register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_period_pend <= '0;
         r_period      <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_duty_pend[i] <= '0;
            r_duty[i]      <= '0;
         end
      end else begin
         r_period_pend <= w_period_fwd;
         r_duty_pend   <= w_duty_fwd;
         if (w_load) begin
            r_period <= w_period_fwd;
            r_duty   <= w_duty_fwd;
         end
      end
   end
`else
   // NOTE: the duty bank is a handful of flops rather than a RAM, so it is
   // reset explicitly like any other register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_period <= '0;
         for (int i = 0; i < NCH; i++) begin
            r_duty[i] <= '0;
         end
      end else if (w_wr) begin
         if (w_off == OFF_PERIOD) begin
            r_period <= w_wdata;
         end
         for (int i = 0; i < NCH; i++) begin
            if (w_off == 4'(i)) begin
               r_duty[i] <= w_wdata;
            end
         end
      end
   end
`endif

   // NOTE: dataOut gets its default before the case so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      dataOut = '0;
      if (w_sel == SEL_READ) begin
         case (w_off)
            OFF_PERIOD: dataOut = 32'(r_period);
            OFF_EN:     dataOut = 32'(r_en);
            OFF_CNT:    dataOut = 32'(r_cnt);
            OFF_STATUS: dataOut = {31'b0, r_wrap_flag};
            default: begin
               for (int i = 0; i < NCH; i++) begin
                  if (w_off == 4'(i)) begin
                     dataOut = 32'(r_duty[i]);
                  end
               end
            end
         endcase
      end
   end

   assign JA = r_ja;

endmodule

// File: tb/tb_io_pwm_bank.sv
// Self-checking bench for io_pwm_bank: vector table, directed PWM/status
// sequences and a randomized run against a frame-level reference model.
module tb_io_pwm_bank;

   localparam int CNT_W = 22;
   localparam int NCH   = 6;
`ifdef IO_PWM_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic             IOinsn;
   logic [31:0]      memAddr;
   logic [31:0]      dataIn;
   logic [31:0]      dataOut;
   logic [NCH-1:0]   JA;

   io_pwm_bank #(.CNT_W(CNT_W), .NCH(NCH)) dut (
      .clock   (clock),
      .reset   (reset),
      .IOinsn  (IOinsn),
      .memAddr (memAddr),
      .dataIn  (dataIn),
      .dataOut (dataOut),
      .JA      (JA)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: architectural state of the peripheral as plain integers.
   int             m_cnt, m_period, m_pperiod, m_en, m_flag;
   int             m_duty [NCH];
   int             m_pduty [NCH];
   logic [NCH-1:0] m_ja;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_period = 0; m_pperiod = 0; m_en = 0; m_flag = 0; m_ja = '0;
      for (int i = 0; i < NCH; i++) begin
         m_duty[i] = 0;
         m_pduty[i] = 0;
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int off;
      off = int'(a[3:0]);
      if (a[13:12] != 2'b10) return 32'd0;
      if (off < NCH) return 32'(m_duty[off]);
      case (off)
         6: return 32'(m_period);
         7: return 32'(m_en);
         8: return 32'(m_cnt);
         9: return 32'(m_flag);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step(input logic io, input logic [31:0] a, input logic [31:0] d, input logic rst);
      int  p, off, wd;
      bit  wr, wrap;
      if (rst) begin
         model_reset();
         return;
      end
      p    = m_period;
      off  = int'(a[3:0]);
      wr   = io && (a[13:12] == 2'b01);
      wd   = int'(d[CNT_W-1:0]);
      wrap = (p != 0) && (m_cnt == p - 1);
      for (int i = 0; i < NCH; i++) begin
         m_ja[i] = (p != 0) && (((m_en >> i) & 1) == 1) && (m_cnt < m_duty[i]);
      end
      m_cnt = (p == 0 || m_cnt >= p - 1) ? 0 : m_cnt + 1;
      if (wrap) m_flag = 1;
      else if (io && a[13:12] == 2'b10 && off == 9) m_flag = 0;
      if (wr && off == 7) m_en = int'(d[NCH-1:0]);
      if (SHADOW) begin
         if (wr && off == 6) m_pperiod = wd;
         if (wr && off < NCH) m_pduty[off] = wd;
         if (wrap || p == 0) begin
            m_period = m_pperiod;
            for (int i = 0; i < NCH; i++) m_duty[i] = m_pduty[i];
         end
      end else begin
         if (wr && off == 6) m_period = wd;
         if (wr && off < NCH) m_duty[off] = wd;
      end
   endtask

   // One bus cycle: drive, check readback mid-cycle, advance model, check JA.
   task automatic drive(input logic io, input logic [31:0] a, input logic [31:0] d,
                        input logic rst, output logic [31:0] dout);
      IOinsn = io; memAddr = a; dataIn = d; reset = rst;
      @(negedge clock);
      dout = dataOut;
      check("dout", dataOut, model_read(a));
      @(posedge clock);
      model_step(io, a, d, rst);
      #1;
      check("ja", 32'(JA), 32'(m_ja));
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      logic [31:0] x;
      drive(1'b1, 32'h0000_1000 | 32'(off), d, 1'b0, x);
   endtask

   task automatic peek(input int off, output logic [31:0] d);
      drive(1'b0, 32'h0000_2000 | 32'(off), 32'd0, 1'b0, d);
   endtask

   task automatic idle(input int n);
      logic [31:0] x;
      for (int i = 0; i < n; i++) peek(8, x);
   endtask

   task automatic wait_read(input int off, input int target);
      logic [31:0] v;
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 40; i++) begin
         peek(off, v);
         if (v == 32'(target)) begin
            hit = 1'b1;
            break;
         end
      end
      check("wait_bound", 32'(hit), 32'd1);
   endtask

   typedef struct {
      logic        io;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish before 1000000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, r0;
      int ones, ones2, orv;

      tbl[0]  = '{1'b0, 32'h0000_2006, 32'd0,         32'd0};
      tbl[1]  = '{1'b0, 32'h0000_2009, 32'd0,         32'd0};
      tbl[2]  = '{1'b1, 32'h0000_1006, 32'd10,        32'd0};
      tbl[3]  = '{1'b0, 32'h0000_2006, 32'd0,         32'd10};
      tbl[4]  = '{1'b1, 32'h0000_1007, 32'hFF,        32'd0};
      tbl[5]  = '{1'b0, 32'h0000_2007, 32'd0,         32'h3F};
      tbl[6]  = '{1'b1, 32'h0000_3007, 32'd0,         32'd0};
      tbl[7]  = '{1'b0, 32'h0000_2007, 32'd0,         32'h3F};
      tbl[8]  = '{1'b0, 32'h0000_3007, 32'd0,         32'd0};
      tbl[9]  = '{1'b0, 32'h0000_0007, 32'd0,         32'd0};
      tbl[10] = '{1'b0, 32'h0000_200A, 32'd0,         32'd0};
      tbl[11] = '{1'b0, 32'h0000_200F, 32'd0,         32'd0};
      tbl[12] = '{1'b0, 32'h0000_1007, 32'd0,         32'd0};
      tbl[13] = '{1'b0, 32'hFFFF_E007, 32'd0,         32'h3F};
      tbl[14] = '{1'b1, 32'h0000_1007, 32'hFFFF_FFC0, 32'd0};
      tbl[15] = '{1'b0, 32'h0000_2007, 32'd0,         32'd0};

      reset = 1'b1; IOinsn = 1'b0; memAddr = '0; dataIn = '0;
      repeat (2) @(posedge clock);
      model_reset();
      #1;
      check("reset_ja", 32'(JA), 32'd0);

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].io, tbl[i].addr, tbl[i].data, 1'b0, d);
         check($sformatf("tbl%0d", i), d, tbl[i].exp);
      end

      // Basic PWM: period 10, duty0 3, channel 0 only.
      wr(6, 10); wr(0, 3); wr(7, 1);
      idle(20);
      ones = 0; orv = 0;
      for (int i = 0; i < 30; i++) begin
         idle(1);
         ones += int'(JA[0]);
         orv  |= int'(JA[5:1]);
      end
      check("pwm_high_30", 32'(ones), 32'd9);
      check("pwm_others", 32'(orv), 32'd0);
      peek(8, r0);
      check("cnt_range", 32'(r0 < 10), 32'd1);
      for (int k = 1; k < 10; k++) begin
         peek(8, d);
         check("cnt_seq", d, (r0 + 32'(k)) % 10);
      end

      // Duty extremes.
      wr(1, 0); wr(2, 15); wr(7, 6);
      idle(20);
      ones = 0; ones2 = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         ones  += int'(JA[1]);
         ones2 += int'(JA[2]);
      end
      check("duty_zero", 32'(ones), 32'd0);
      check("duty_full", 32'(ones2), 32'd20);

      // Duty update at cnt = 4.
      wr(7, 1);
      wait_read(8, 3);
      wr(0, 8);
      if (SHADOW) begin
         for (int k = 0; k < 5; k++) begin
            peek(0, d);
            check("shadow_hold", d, 32'd3);
            check("shadow_tail", 32'(JA[0]), 32'd0);
         end
         ones = 0;
         for (int k = 0; k < 10; k++) begin
            peek(0, d);
            check("shadow_new", d, 32'd8);
            ones += int'(JA[0]);
         end
         check("shadow_frame", 32'(ones), 32'd8);
      end else begin
         ones = 0;
         for (int k = 0; k < 5; k++) begin
            peek(0, d);
            check("direct_new", d, 32'd8);
            ones += int'(JA[0]);
         end
         check("direct_tail", 32'(ones), 32'd3);
      end

      // Sticky wrap flag.
      wait_read(9, 1);
      drive(1'b1, 32'h0000_2009, 32'd0, 1'b0, d);
      check("stat_read", d, 32'd1);
      peek(9, d);
      check("stat_cleared", d, 32'd0);
      wait_read(8, 8);
      drive(1'b1, 32'h0000_2009, 32'd0, 1'b0, d);
      check("stat_coin_rd", d, 32'd0);
      peek(9, d);
      check("stat_coin_set", d, 32'd1);

      // Period 0 and invalid space.
      wr(6, 0);
      idle(15);
      for (int k = 0; k < 5; k++) begin
         peek(8, d);
         check("p0_cnt", d, 32'd0);
         check("p0_ja", 32'(JA), 32'd0);
      end
      drive(1'b1, 32'h0000_3006, 32'd5, 1'b0, d);
      check("inv_wr_dout", d, 32'd0);
      peek(6, d);
      check("inv_no_write", d, 32'd0);

      // Randomized traffic against the model.
      wr(6, 7);
      for (int n = 0; n < 700; n++) begin
         int r, off;
         logic [31:0] a, dat;
         r   = int'($urandom_range(0, 99));
         off = int'($urandom_range(0, 15));
         a   = {$urandom() & 32'hFFFF_C000} | ($urandom() & 32'h0000_0FF0) | 32'(off);
         dat = $urandom() & 32'hFFC0_0000;
         if (off == 6)      dat |= 32'($urandom_range(0, 16));
         else if (off < 6)  dat |= 32'($urandom_range(0, 20));
         else               dat |= $urandom() & 32'h003F_FFFF;
         if (r < 2)       drive(1'b0, a, dat, 1'b1, d);
         else if (r < 30) drive(1'b1, (a & ~32'h3000) | 32'h1000, dat, 1'b0, d);
         else if (r < 45) drive(1'b1, 32'h0000_2009, dat, 1'b0, d);
         else if (r < 55) drive(1'b1, a | 32'h3000, dat, 1'b0, d);
         else if (r < 65) drive(1'b1, a & ~32'h3000, dat, 1'b0, d);
         else             drive(1'b0, (a & ~32'h3000) | 32'h2000, dat, 1'b0, d);
      end

      // Reset after arbitrary prior state.
      wr(6, 9); wr(3, 4); wr(7, 8);
      drive(1'b0, 32'h0000_2008, 32'd0, 1'b1, d);
      drive(1'b0, 32'h0000_2008, 32'd0, 1'b1, d);
      check("post_rst_ja", 32'(JA), 32'd0);
      for (int k = 0; k < 10; k++) begin
         peek(k, d);
         check($sformatf("post_rst_off%0d", k), d, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
